// File: rtl/multicycle_control_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_pkg
// Shared definitions for the multicycle datapath controller. It holds:
//   - the opcode constants
//   - the ALU operation codes (ADD, SUB, LUI)
//   - the PC source select codes
//   - the FSM state encoding, which is also exported on the state port
//   - the one-hot instruction class produced by mctrl_opdecode
// Ports: none (package).
// Optional feature: MCTRL_ADDI_EN (decoded in mctrl_opdecode).
// ---------------------------------------------------------------------------
package multicycle_control_pkg;

  // Opcodes as they appear in the instruction register
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // ALU operation codes (3 LSBs of alu_op)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_LUI = 3'b110;

  // PC source select codes
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_BRANCH = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // FSM state encoding; these codes are visible on the state output
  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_WB_R     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_EXEC_LUI = 4'd10,
    ST_WB_I     = 4'd11
  } state_t;

  // One-hot instruction class; at most one bit is set
  typedef struct packed {
    logic r;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic addi;
  } op_class_t;

  // Returns 1 for states that wait on mem_ready and run the wait counter
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_opdecode.sv
// ---------------------------------------------------------------------------
// mctrl_opdecode
// Combinational opcode classifier. It maps the 6-bit opcode onto a one-hot
// instruction class and flags every opcode that is not decoded.
// Ports:
//   i_op      in  6  opcode
//   o_cls     out    one-hot instruction class (op_class_t)
//   o_illegal out 1  opcode is not a supported instruction
// Optional feature: MCTRL_ADDI_EN. When it is defined, ADDI decodes to its
// own class. When it is undefined, ADDI is reported as illegal.
// ---------------------------------------------------------------------------
module mctrl_opdecode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] i_op,
  output op_class_t  o_cls,
  output logic       o_illegal
);

  // Classify the opcode; anything unrecognised is illegal
  always_comb begin
    o_cls     = '0;
    o_illegal = 1'b0;
    case (i_op)
      OP_R:    o_cls.r   = 1'b1;
      OP_LW:   o_cls.lw  = 1'b1;
      OP_SW:   o_cls.sw  = 1'b1;
      OP_BEQ:  o_cls.beq = 1'b1;
      OP_LUI:  o_cls.lui = 1'b1;
      OP_J:    o_cls.j   = 1'b1;
`ifdef MCTRL_ADDI_EN
      OP_ADDI: o_cls.addi = 1'b1;
`endif
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Main control FSM for a multicycle MIPS-style datapath.
//
// Datapath controls are a pure combinational function of the current state,
// op and mem_ready. The wait counter aborts any memory access that stalls for
// FETCH_WAIT_MAX consecutive cycles; the abort is signalled on mem_err.
//
// Parameters:
//   ALU_OP_W        width of alu_op (>= 3); upper bits are zero
//   FETCH_WAIT_MAX  mem_ready=0 cycles tolerated before mem_err (>= 1)
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   op[5:0], mem_ready                opcode, memory-complete strobe
//   mem_req, iord, ir_write,          memory / datapath controls
//   mem_write, mem_to_reg, reg_dst, reg_write
//   alu_src_a, alu_src_b[1:0], alu_op, r_type
//   pc_source[1:0], pc_write, pc_write_cond
//   illegal_op, mem_err               single-cycle event pulses
//   state[3:0]                        current state code
//
// Optional feature: MCTRL_ADDI_EN. When it is defined, ADDI runs through
// EXEC_LUI and WB_I with an ADD ALU operation.
// ---------------------------------------------------------------------------
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int ALU_OP_W       = 3,
  parameter int FETCH_WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          op,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                iord,
  output logic                ir_write,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_source,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                r_type,
  output logic                illegal_op,
  output logic                mem_err,
  output logic [3:0]          state
);

  localparam int CNT_W = $clog2(FETCH_WAIT_MAX + 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait;
  logic [CNT_W-1:0] w_wait_next;
  op_class_t        w_cls;
  logic             w_illegal;
  logic             w_rdy;
  logic             w_timeout;
  logic [2:0]       w_alu_op3;

  mctrl_opdecode u_opdecode (
    .i_op      (op),
    .o_cls     (w_cls),
    .o_illegal (w_illegal)
  );

  // Masking mem_ready while in reset makes the outputs match FETCH with
  // mem_ready=0: mem_req stays high and no write enable can fire.
  assign w_rdy = mem_ready & rst_n;

  // This is the FETCH_WAIT_MAX-th consecutive stalled cycle of an access.
  assign w_timeout = is_mem_state(r_state) && !w_rdy &&
                     (r_wait == CNT_W'(FETCH_WAIT_MAX - 1));

  assign mem_err = w_timeout & rst_n;
  assign state   = r_state;
  assign alu_op  = ALU_OP_W'(w_alu_op3);

  // Stall counter: counts only while stalled in a memory state; any exit
  // clears it
  always_comb begin
    w_wait_next = '0;
    if (is_mem_state(r_state) && !w_rdy && !w_timeout) begin
      w_wait_next = r_wait + CNT_W'(1);
    end else begin
      w_wait_next = '0;
    end
  end

  // Next-state logic and per-state datapath controls
  always_comb begin
    w_next        = ST_FETCH;
    mem_req       = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = PCS_ALU;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    w_alu_op3     = ALU_ADD;
    r_type        = 1'b0;
    illegal_op    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (w_timeout) begin
          w_next = ST_FETCH;
        end else if (w_rdy) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = ST_DECODE;
        end else begin
          w_next = ST_FETCH;
        end
      end
      ST_DECODE: begin
        alu_src_b = 2'b11;
        if (w_illegal) begin
          illegal_op = 1'b1;
          w_next     = ST_FETCH;
        end else if (w_cls.lw || w_cls.sw) begin
          w_next = ST_MEM_ADDR;
        end else if (w_cls.r) begin
          w_next = ST_EXEC_R;
        end else if (w_cls.beq) begin
          w_next = ST_BRANCH;
        end else if (w_cls.j) begin
          w_next = ST_JUMP;
        end else if (w_cls.lui || w_cls.addi) begin
          w_next = ST_EXEC_LUI;
        end else begin
          w_next = ST_FETCH;
        end
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (w_cls.lw) begin
          w_next = ST_MEM_RD;
        end else if (w_cls.sw) begin
          w_next = ST_MEM_WR;
        end else begin
          w_next = ST_FETCH;
        end
      end
      ST_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (w_timeout) begin
          w_next = ST_FETCH;
        end else if (w_rdy) begin
          w_next = ST_MEM_WB;
        end else begin
          w_next = ST_MEM_RD;
        end
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
        if (w_timeout || w_rdy) begin
          w_next = ST_FETCH;
        end else begin
          w_next = ST_MEM_WR;
        end
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        r_type    = 1'b1;
        w_next    = ST_WB_R;
      end
      ST_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_next    = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        w_alu_op3     = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCS_BRANCH;
        w_next        = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCS_JUMP;
        w_next    = ST_FETCH;
      end
      ST_EXEC_LUI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // The IR still holds the opcode here, so ADDI is told apart from LUI
        if (w_cls.addi) begin
          w_alu_op3 = ALU_ADD;
        end else begin
          w_alu_op3 = ALU_LUI;
        end
        w_next = ST_WB_I;
      end
      ST_WB_I: begin
        reg_write = 1'b1;
        w_next    = ST_FETCH;
      end
      default: begin
        w_next = ST_FETCH;
      end
    endcase
  end

  // State and stall-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Self-checking bench for multicycle_control.
//
// Each instruction is expanded from its recipe into an expected per-cycle
// trace. A trace step holds three things: the mem_ready value to drive, the
// expected state, and the expected control word. Memory phases are expanded
// from a chosen stall length. Non-memory cycles drive a random mem_ready,
// which the design must ignore.
//
// Macro MCTRL_ADDI_EN selects whether ADDI is expected to be legal.
// ---------------------------------------------------------------------------
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  localparam int FWM = 15;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic [2:0] alu_op;
    logic       r_type;
    logic       illegal_op;
    logic       mem_err;
  } ctrl_t;

  typedef struct packed {
    logic       rdy;
    logic [3:0] st;
    ctrl_t      c;
  } step_t;

  typedef enum {K_R, K_LW, K_SW, K_BEQ, K_LUI, K_J, K_ADDI, K_ILL} kind_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'b000000;
  logic       mem_ready = 1'b0;
  logic       mem_req, iord, ir_write, mem_write, mem_to_reg, reg_dst, reg_write;
  logic       alu_src_a, pc_write, pc_write_cond, r_type, illegal_op, mem_err;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
  ctrl_t      obs;

  step_t q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cnt_mw   = 0;
  int    cnt_rw   = 0;
  int    cnt_irw  = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ALU_OP_W(3), .FETCH_WAIT_MAX(FWM)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .ir_write(ir_write), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .alu_op(alu_op),
    .r_type(r_type), .illegal_op(illegal_op), .mem_err(mem_err), .state(state)
  );

  assign obs = {mem_req, iord, ir_write, mem_write, mem_to_reg, reg_dst, reg_write,
                alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond, alu_op,
                r_type, illegal_op, mem_err};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected controls for one cycle in state s (rdy = mem_ready that cycle)
  function automatic ctrl_t exp_ctrl(input state_t s, input logic rdy, input logic err,
                                     input logic addi);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy;
                         c.pc_write = rdy; c.mem_err = err; end
      ST_DECODE:   c.alu_src_b = 2'b11;
      ST_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      ST_MEM_RD:   begin c.mem_req = 1'b1; c.iord = 1'b1; c.mem_err = err; end
      ST_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      ST_MEM_WR:   begin c.mem_req = 1'b1; c.iord = 1'b1; c.mem_write = 1'b1;
                         c.mem_err = err; end
      ST_EXEC_R:   begin c.alu_src_a = 1'b1; c.r_type = 1'b1; end
      ST_WB_R:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      ST_BRANCH:   begin c.alu_src_a = 1'b1; c.alu_op = 3'b100; c.pc_write_cond = 1'b1;
                         c.pc_source = 2'b01; end
      ST_JUMP:     begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      ST_EXEC_LUI: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                         c.alu_op = addi ? 3'b000 : 3'b110; end
      ST_WB_I:     c.reg_write = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  function automatic kind_t kind_of(input logic [5:0] o);
    kind_t k;
    case (o)
      6'b000000: k = K_R;
      6'b100011: k = K_LW;
      6'b101011: k = K_SW;
      6'b000100: k = K_BEQ;
      6'b001111: k = K_LUI;
      6'b000010: k = K_J;
      6'b001000: begin
`ifdef MCTRL_ADDI_EN
        k = K_ADDI;
`else
        k = K_ILL;
`endif
      end
      default:   k = K_ILL;
    endcase
    return k;
  endfunction

  task automatic push(input state_t s, input logic rdy, input logic err, input logic addi,
                      input logic ill);
    step_t e;
    e.rdy = rdy;
    e.st  = s;
    e.c   = exp_ctrl(s, rdy, err, addi);
    e.c.illegal_op = ill;
    q.push_back(e);
  endtask

  // Non-memory cycle: mem_ready is random and must have no effect
  task automatic push_any(input state_t s, input logic addi, input logic ill);
    push(s, 1'($urandom_range(0, 1)), 1'b0, addi, ill);
  endtask

  // Memory phase with d stall cycles; d >= FWM ends in an abort
  task automatic push_mem(input state_t s, input int d, output bit aborted);
    if (d >= FWM) begin
      for (int i = 0; i < FWM; i++) push(s, 1'b0, (i == FWM - 1), 1'b0, 1'b0);
      aborted = 1'b1;
    end else begin
      for (int i = 0; i < d; i++) push(s, 1'b0, 1'b0, 1'b0, 1'b0);
      push(s, 1'b1, 1'b0, 1'b0, 1'b0);
      aborted = 1'b0;
    end
  endtask

  task automatic build(input logic [5:0] o, input int fd, input int md);
    bit    ab;
    kind_t k;
    push_mem(ST_FETCH, fd, ab);
    // After a fetch abort, the retry stalls FWM-1 cycles; a counter that was
    // not cleared by the abort would raise a second, spurious error here
    if (ab) push_mem(ST_FETCH, FWM - 1, ab);
    k = kind_of(o);
    push_any(ST_DECODE, 1'b0, (k == K_ILL));
    case (k)
      K_LW:   begin push_any(ST_MEM_ADDR, 1'b0, 1'b0); push_mem(ST_MEM_RD, md, ab);
                    if (!ab) push_any(ST_MEM_WB, 1'b0, 1'b0); end
      K_SW:   begin push_any(ST_MEM_ADDR, 1'b0, 1'b0); push_mem(ST_MEM_WR, md, ab); end
      K_R:    begin push_any(ST_EXEC_R, 1'b0, 1'b0); push_any(ST_WB_R, 1'b0, 1'b0); end
      K_BEQ:  push_any(ST_BRANCH, 1'b0, 1'b0);
      K_J:    push_any(ST_JUMP, 1'b0, 1'b0);
      K_LUI, K_ADDI: begin push_any(ST_EXEC_LUI, (k == K_ADDI), 1'b0);
                           push_any(ST_WB_I, 1'b0, 1'b0); end
      default: ;
    endcase
  endtask

  // Each step starts just after a falling edge; outputs are checked 1 time unit later
  task automatic run_steps(input int n);
    step_t e;
    for (int i = 0; i < n; i++) begin
      if (q.size() == 0) break;
      e = q.pop_front();
      mem_ready = e.rdy;
      #1;
      check_eq($sformatf("state(exp st %0d)", e.st), 32'(state), 32'(e.st));
      check_eq($sformatf("ctrl(st %0d)", e.st), 32'(obs), 32'(e.c));
      if (mem_write) cnt_mw++;
      if (reg_write) cnt_rw++;
      if (ir_write) cnt_irw++;
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input int fd, input int md);
    op = o;
    build(o, fd, md);
    run_steps(q.size());
  endtask

  function automatic int rnd_delay();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(FWM - 1, FWM + 1));
    else return int'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [5:0] legal [7];
    logic [5:0] o;
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001111, 6'b000010, 6'b001000};

    // During reset: FETCH outputs with mem_ready taken as 0, even while it is driven high
    mem_ready = 1'b1;
    op = 6'b100011;
    #12;
    check_eq("reset_state", 32'(state), 32'(ST_FETCH));
    check_eq("reset_ctrl", 32'(obs), 32'(exp_ctrl(ST_FETCH, 1'b0, 1'b0, 1'b0)));
    @(negedge clk);
    rst_n = 1'b1;

    // LW with mem_ready always high: 5 states, exactly one reg_write
    cnt_rw = 0;
    run_instr(6'b100011, 0, 0);
    check_eq("lw_reg_write_count", 32'(cnt_rw), 32'd1);

    // SW that stalls 3 cycles in MEM_WR: mem_write is high for 4 cycles
    cnt_mw = 0;
    run_instr(6'b101011, 0, 3);
    check_eq("sw_mem_write_cycles", 32'(cnt_mw), 32'd4);

    // Illegal opcode: no write enables at all
    cnt_rw = 0; cnt_mw = 0;
    run_instr(6'b111111, 0, 0);
    check_eq("illegal_no_writes", 32'(cnt_rw + cnt_mw), 32'd0);

    // Fetch timeout: ir_write never fires during the FWM stalled cycles
    cnt_irw = 0;
    op = 6'b000010;
    build(6'b000010, FWM, 0);
    run_steps(FWM);
    check_eq("fetch_timeout_no_ir_write", 32'(cnt_irw), 32'd0);
    run_steps(q.size());

    // BEQ then LUI back to back, followed by the remaining instruction classes
    run_instr(6'b000100, 0, 0);
    run_instr(6'b001111, 0, 0);
    run_instr(6'b000000, 1, 0);
    run_instr(6'b001000, 0, 0);
    run_instr(6'b000010, 2, 0);

    // Stall boundaries in MEM_RD and MEM_WR
    run_instr(6'b100011, 0, FWM - 1);
    run_instr(6'b100011, 0, FWM);
    run_instr(6'b101011, 0, FWM - 1);
    run_instr(6'b101011, 0, FWM);

    // Reset asserted while LW stalls in MEM_RD
    cnt_rw = 0;
    op = 6'b100011;
    build(6'b100011, 0, 8);
    run_steps(5);
    q.delete();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_eq("midreset_state", 32'(state), 32'(ST_FETCH));
    check_eq("midreset_ctrl", 32'(obs), 32'(exp_ctrl(ST_FETCH, 1'b0, 1'b0, 1'b0)));
    repeat (2) begin
      @(negedge clk);
      #1;
      check_eq("midreset_hold_state", 32'(state), 32'(ST_FETCH));
      if (reg_write) cnt_rw++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midreset_no_reg_write", 32'(cnt_rw), 32'd0);

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 7) o = legal[$urandom_range(0, 6)];
      else o = 6'($urandom());
      run_instr(o, rnd_delay(), rnd_delay());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
